// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the framebuffer plot receiver:
//   - default screen geometry and framebuffer size
//   - field widths of a queued pixel write {x, y, colour}
//   - control state encoding
//   - pixel address helper (addr = y*160 + x, built from shifts)
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam int H_RES_DEF = 160;
  localparam int V_RES_DEF = 120;
  localparam int FB_WORDS  = 19200;
  localparam int ADDR_W    = 15;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int ENTRY_W  = X_W + Y_W + COLOUR_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_t;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  // y*160 + x as (y<<7) + (y<<5) + x; in-range coordinates never exceed 19199
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] px,
                                                   input logic [Y_W-1:0] py);
    logic [ADDR_W-1:0] yw;
    logic [ADDR_W-1:0] xw;
    yw = {{(ADDR_W-Y_W){1'b0}}, py};
    xw = {{(ADDR_W-X_W){1'b0}}, px};
    return (yw << 3'd7) + (yw << 3'd5) + xw;
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// -----------------------------------------------------------------------------
// plot_fifo
// Synchronous FIFO holding queued pixel writes.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, din         write request and entry (ignored when full)
//   pop               read request (ignored when empty); dout shows the head
//   full, empty       occupancy flags
// Pointers carry one extra wrap bit so full and empty are told apart.
// -----------------------------------------------------------------------------
module plot_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic         do_push_s;
  logic         do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Storage array; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  // Read and write pointer advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/fb_plot_receiver.sv
// -----------------------------------------------------------------------------
// fb_plot_receiver
// Receiving end of the painter's plot/x/y interface. Pixel writes are queued in
// a small FIFO, popped one per cycle, bounds-checked, and written to the
// 160x120 framebuffer at y*160 + x. A clear request drains the queue first and
// then writes CLEAR_COLOUR to every framebuffer word in ascending order.
// Ports:
//   CLOCK_50, resetn         clock, asynchronous active-low reset
//   plot, x, y, colour       pixel write request (taken when plot && plot_ready)
//   plot_ready               combinational: room in FIFO and no clear under way
//   clear_req, clear_done    clear request pulse / completion pulse
//   busy                     registered: queue non-empty, clear pending or clearing
//   mem_addr/data/wren       registered framebuffer write port
//   oob_count                (only with `PLOT_OOB_COUNT_EN) saturating count of
//                            out-of-range entries dropped
// Configuration macro: PLOT_OOB_COUNT_EN
// -----------------------------------------------------------------------------
module fb_plot_receiver
  import fb_pkg::*;
#(
  parameter int                  H_RES        = H_RES_DEF,
  parameter int                  V_RES        = V_RES_DEF,
  parameter int                  FIFO_DEPTH   = 8,
  parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = 3'b000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                plot,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  input  logic [COLOUR_W-1:0] colour,
  output logic                plot_ready,
  input  logic                clear_req,
  output logic                clear_done,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_wren
`ifdef PLOT_OOB_COUNT_EN
  ,
  output logic [7:0]          oob_count
`endif
);

  localparam logic [X_W-1:0]    H_LIM    = X_W'(H_RES);
  localparam logic [Y_W-1:0]    V_LIM    = Y_W'(V_RES);
  localparam logic [ADDR_W-1:0] FB_COUNT = ADDR_W'(H_RES * V_RES);

  fb_state_t           state_r;
  logic                clear_pending_r;
  logic [ADDR_W-1:0]   clear_cnt_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [COLOUR_W-1:0] mem_data_r;
  logic                mem_wren_r;
  logic                clear_done_r;
  logic                busy_r;

  pixel_t              fifo_din_s;
  pixel_t              head_s;
  logic [ENTRY_W-1:0]  fifo_dout_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                push_s;
  logic                pop_s;
  logic                in_range_s;
  logic [ADDR_W-1:0]   head_addr_s;
  logic                clear_accept_s;

  assign plot_ready = !fifo_full_s && !clear_pending_r && (state_r != ST_CLEAR);
  assign push_s     = plot && plot_ready;
  // Pop only what was already queued before this edge; a same-cycle push waits
  assign pop_s      = (state_r == ST_IDLE) && !fifo_empty_s;

  assign fifo_din_s     = '{x: x, y: y, colour: colour};
  assign head_s         = pixel_t'(fifo_dout_s);
  assign in_range_s     = (head_s.x < H_LIM) && (head_s.y < V_LIM);
  assign head_addr_s    = pixel_addr(head_s.x, head_s.y);
  assign clear_accept_s = clear_req && !clear_pending_r && (state_r == ST_IDLE);

  assign mem_addr   = mem_addr_r;
  assign mem_data   = mem_data_r;
  assign mem_wren   = mem_wren_r;
  assign clear_done = clear_done_r;
  assign busy       = busy_r;

  plot_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_plot_fifo (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .push  (push_s),
    .din   (fifo_din_s),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Control FSM: drains the queue to the write port, then runs the clear sweep
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_r         <= ST_IDLE;
      clear_pending_r <= 1'b0;
      clear_cnt_r     <= '0;
      mem_addr_r      <= '0;
      mem_data_r      <= '0;
      mem_wren_r      <= 1'b0;
      clear_done_r    <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      busy_r <= !fifo_empty_s || clear_pending_r || (state_r == ST_CLEAR);
      case (state_r)
        ST_IDLE: begin
          clear_done_r <= 1'b0;
          if (clear_accept_s) begin
            clear_pending_r <= 1'b1;
          end
          if (pop_s) begin
            // Out-of-range entries are consumed without a write
            mem_wren_r <= in_range_s;
            if (in_range_s) begin
              mem_addr_r <= head_addr_s;
              mem_data_r <= head_s.colour;
            end
          end else begin
            mem_wren_r <= 1'b0;
            // Queue is empty here, so everything before the request is written
            if (clear_pending_r) begin
              state_r         <= ST_CLEAR;
              clear_pending_r <= 1'b0;
              clear_cnt_r     <= '0;
            end
          end
        end
        ST_CLEAR: begin
          if (clear_cnt_r < FB_COUNT) begin
            mem_addr_r   <= clear_cnt_r;
            mem_data_r   <= CLEAR_COLOUR;
            mem_wren_r   <= 1'b1;
            clear_done_r <= 1'b0;
            clear_cnt_r  <= clear_cnt_r + 15'd1;
          end else if (!clear_done_r) begin
            // Sweep finished: one cycle of clear_done while still holding off plots
            mem_wren_r   <= 1'b0;
            clear_done_r <= 1'b1;
          end else begin
            mem_wren_r   <= 1'b0;
            clear_done_r <= 1'b0;
            clear_cnt_r  <= '0;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          mem_wren_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLOT_OOB_COUNT_EN
  logic [7:0] oob_cnt_r;

  assign oob_count = oob_cnt_r;

  // Saturating count of out-of-range entries dropped at pop time
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      oob_cnt_r <= 8'd0;
    end else if (pop_s && !in_range_s && (oob_cnt_r != 8'd255)) begin
      oob_cnt_r <= oob_cnt_r + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_plot_receiver.sv
// -----------------------------------------------------------------------------
// tb_fb_plot_receiver
// Randomized and directed stimulus for fb_plot_receiver, compared every cycle
// against a queue-based reference model of the pixel receiver.
// -----------------------------------------------------------------------------
module tb_fb_plot_receiver;

  localparam int FBW = 19200;

  logic        CLOCK_50 = 1'b0;
  logic        resetn   = 1'b0;
  logic        plot     = 1'b0;
  logic        clear_req = 1'b0;
  logic [7:0]  x = 8'd0;
  logic [6:0]  y = 7'd0;
  logic [2:0]  colour = 3'd0;
  logic        plot_ready;
  logic        clear_done;
  logic        busy;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_wren;
`ifdef PLOT_OOB_COUNT_EN
  logic [7:0]  oob_count;
`endif

  fb_plot_receiver dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .plot       (plot),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot_ready (plot_ready),
    .clear_req  (clear_req),
    .clear_done (clear_done),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren)
`ifdef PLOT_OOB_COUNT_EN
    ,
    .oob_count  (oob_count)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int px;
    int py;
    int pc;
  } pix_t;

  // Reference model state
  pix_t m_q[$];
  bit   m_pend;
  bit   m_clr;
  int   m_idx;
  int   m_oob;
  bit   last_acc;
  int   done_cnt;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend   = 1'b0;
    m_clr    = 1'b0;
    m_idx    = 0;
    m_oob    = 0;
    last_acc = 1'b0;
  endtask

  // One clock: predict, apply the edge, compare outputs with the model
  task automatic cycle();
    bit   exp_ready, acc, clr_acc, exp_busy, exp_wren, exp_done;
    int   exp_addr, exp_data;
    pix_t in_pix, e;
    exp_ready = (m_q.size() < 8) && !m_pend && !m_clr;
    check("plot_ready", 32'(plot_ready), 32'(exp_ready));
    acc      = plot && exp_ready;
    clr_acc  = clear_req && !m_pend && !m_clr;
    exp_busy = (m_q.size() != 0) || m_pend || m_clr;
    in_pix   = '{int'(x), int'(y), int'(colour)};
    @(posedge CLOCK_50);
    #1;
    exp_wren = 1'b0;
    exp_done = 1'b0;
    exp_addr = 0;
    exp_data = 0;
    if (m_clr) begin
      if (m_idx < FBW) begin
        exp_wren = 1'b1;
        exp_addr = m_idx;
        exp_data = 0;
        m_idx++;
      end else if (m_idx == FBW) begin
        exp_done = 1'b1;
        m_idx++;
      end else begin
        m_clr = 1'b0;
      end
    end else if (m_q.size() != 0) begin
      e = m_q.pop_front();
      if (e.px < 160 && e.py < 120) begin
        exp_wren = 1'b1;
        exp_addr = e.py * 160 + e.px;
        exp_data = e.pc;
      end else if (m_oob < 255) begin
        m_oob++;
      end
    end else if (m_pend) begin
      m_pend = 1'b0;
      m_clr  = 1'b1;
      m_idx  = 0;
    end
    if (clr_acc) m_pend = 1'b1;
    if (acc) m_q.push_back(in_pix);
    last_acc = acc;
    if (clear_done === 1'b1) done_cnt++;
    check("mem_wren", 32'(mem_wren), 32'(exp_wren));
    check("clear_done", 32'(clear_done), 32'(exp_done));
    check("busy", 32'(busy), 32'(exp_busy));
    if (exp_wren) begin
      check("mem_addr", 32'(mem_addr), exp_addr);
      check("mem_data", 32'(mem_data), exp_data);
    end
`ifdef PLOT_OOB_COUNT_EN
    check("oob_count", 32'(oob_count), m_oob);
`endif
  endtask

  task automatic pick_pixel(input bit allow_oob);
    if (allow_oob && $urandom_range(0, 9) == 0) x = 8'($urandom_range(160, 255));
    else x = 8'($urandom_range(0, 159));
    if (allow_oob && $urandom_range(0, 9) == 0) y = 7'($urandom_range(120, 127));
    else y = 7'($urandom_range(0, 119));
    colour = 3'($urandom_range(0, 7));
  endtask

  // Random plots; a request not yet accepted is held unchanged
  task automatic rand_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      if (!plot || last_acc) begin
        plot = ($urandom_range(0, 3) != 0);
        pick_pixel(1'b1);
      end
      cycle();
    end
    plot = 1'b0;
  endtask

  // Asynchronous reset between edges; outputs must clear immediately
  task automatic do_reset();
    plot      = 1'b0;
    clear_req = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("rst_mem_wren", 32'(mem_wren), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", 32'(mem_data), 32'd0);
    check("rst_clear_done", 32'(clear_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #2 resetn = 1'b1;
    @(posedge CLOCK_50);
    #1;
    check("rst_plot_ready", 32'(plot_ready), 32'd1);
    check("rst_idle_wren", 32'(mem_wren), 32'd0);
  endtask

  initial begin
    int guard;
    model_reset();
    done_cnt = 0;

    // Power-on reset
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("por_mem_wren", 32'(mem_wren), 32'd0);
    check("por_busy", 32'(busy), 32'd0);
    check("por_clear_done", 32'(clear_done), 32'd0);
    #1 resetn = 1'b1;
    @(posedge CLOCK_50);
    #1;
    check("por_plot_ready", 32'(plot_ready), 32'd1);

    // Single plot x=5 y=3 colour=4: write appears after the second edge
    plot = 1'b1; x = 8'd5; y = 7'd3; colour = 3'b100;
    cycle();
    plot = 1'b0;
    cycle();
    check("single_wren", 32'(mem_wren), 32'd1);
    check("single_addr", 32'(mem_addr), 32'd485);
    check("single_data", 32'(mem_data), 32'd4);
    repeat (2) cycle();

    // Back-to-back burst of 12
    for (int i = 0; i < 12; i++) begin
      plot = 1'b1;
      pick_pixel(1'b0);
      cycle();
    end
    plot = 1'b0;
    repeat (3) cycle();

    // Out-of-range entries are dropped
    do_reset();
    plot = 1'b1; x = 8'd160; y = 7'd0; colour = 3'd7;
    cycle();
    x = 8'd0; y = 7'd120;
    cycle();
    plot = 1'b0;
    repeat (3) cycle();
`ifdef PLOT_OOB_COUNT_EN
    check("oob_two", 32'(oob_count), 32'd2);
`endif

    // Random traffic with a reset in the middle of it
    rand_traffic(400);
    for (int i = 0; i < 5; i++) begin
      plot = 1'b1;
      pick_pixel(1'b1);
      cycle();
    end
    do_reset();
    rand_traffic(400);
    repeat (2) cycle();

    // Clear with three plots queued ahead of it; a second request is ignored
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      plot = 1'b1;
      pick_pixel(1'b0);
      clear_req = (i == 2);
      cycle();
    end
    clear_req = 1'b0;
    pick_pixel(1'b0);
    guard = 0;
    while ((m_pend || m_clr) && guard < 20000) begin
      clear_req = (m_clr && m_idx == 100);
      cycle();
      guard++;
    end
    clear_req = 1'b0;
    check("clear_timeout", 32'(guard < 20000), 32'd1);
    check("clear_done_pulses", 32'(done_cnt), 32'd1);
    cycle();
    plot = 1'b0;
    repeat (3) cycle();

    // Reset in the middle of a clear, right after address 5000 is written
    done_cnt = 0;
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    guard = 0;
    while (!(m_clr && m_idx == 5001) && guard < 6000) begin
      cycle();
      guard++;
    end
    check("clear5000_timeout", 32'(guard < 6000), 32'd1);
    check("clear5000_addr", 32'(mem_addr), 32'd5000);
    do_reset();
    repeat (30) cycle();
    check("no_done_after_abort", 32'(done_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
